data_mem_ctl: RTL and testbench
===============================

# data_mem_ctl

Parametrised successor to the processor's byte data memory: a single-clock, word-width/depth-configurable store with a CPU port and a second, handshaked load port for testbench/DMA preloading. After reset it runs a hardware clear sweep, selects combinational or registered read timing per parameter, and can mirror a low-address window to dedicated outputs for harness observation. It sits between the datapath's address/ALU stage and writeback, replacing the fixed 8×256 memory.

## Interface
- W, 8: data word width in bits
- AW, 8: address width in bits
- DEPTH, 256: number of words; must be ≤ 2**AW
- READ_LATENCY, 0: 0 = combinational read, 1 = registered read
- WIN, 4: number of mirrored low words, 1..DEPTH

- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- DataAddress  input  AW  CPU word address
- ReadMem  input  1  CPU read enable (loads DataOut when READ_LATENCY=1)
- WriteMem  input  1  CPU write enable
- DataIn  input  W  CPU write data
- DataOut  output  W  CPU read data
- Ready  output  1  high once the clear sweep completes
- LoadValid  input  1  load-port request
- LoadReady  output  1  load port can accept this cycle
- LoadAddr  input  AW  load-port word address
- LoadData  input  W  load-port write data
- WindowOut  output  WIN×W  mirror of words 0..WIN-1

## Operation
- FSM states: CLEAR, READY. reset (any cycle, including mid-sweep) → CLEAR with sweep counter = 0.
- CLEAR: one word per cycle, core[cnt] ← 0, cnt increments; at cnt = DEPTH-1 the write completes and FSM → READY next cycle. CPU and load writes ignored; Ready=0, LoadReady=0.
- READY: Ready=1. CPU write: WriteMem=1 → core[DataAddress] ← DataIn.
- Load port: LoadReady = Ready & ~WriteMem (CPU has priority). Transfer when LoadValid & LoadReady → core[LoadAddr] ← LoadData. LoadValid must remain asserted with stable LoadAddr/LoadData until transfer.
- Out-of-range (address ≥ DEPTH): writes dropped from either port; reads return 0.
- READ_LATENCY=0: DataOut = core[DataAddress] continuously; ReadMem ignored.
- READ_LATENCY=1: ReadMem=1 → DataOut register ← core[DataAddress] (pre-write value, read-first); ReadMem=0 → DataOut holds.

## Timing
- Reset values: Ready=0, LoadReady=0, registered DataOut=0, WindowOut all 0, FSM=CLEAR.
- Clear sweep: Ready rises exactly DEPTH cycles after the first edge with reset low.
- Write visible on combinational read the cycle after the write edge; registered read returns it one cycle after ReadMem is sampled following the write.
- Same-address CPU read and write, latency 1: DataOut gets old data; new data on next read.
- WindowOut updates on the same edge as the core write that changes it (either port or clear).

## Configuration
- DATA_MEM_WINDOW_EN defined: WindowOut is a registered copy of words 0..WIN-1, kept in sync with every write path.
- Not defined: mirror registers are absent; WindowOut tied to 0; port list unchanged so the harness still elaborates.

## Structure
- Package data_mem_pkg: state enum typedef (CLEAR, READY) and default constants for W, AW, DEPTH, WIN.
- Sub-module data_mem_clear_seq: FSM plus sweep counter, producing Ready, clear write-enable and clear address; the top owns the array, port muxing and read path.

## Test plan
- reset for 2 cycles, DEPTH=256 → Ready=0 for 256 cycles, then 1; reads of 0x00, 0x7F, 0xFF return 0x00.
- reset asserted at sweep count 100 after core[200] preloaded with 0xAA → sweep restarts at 0; Ready 256 cycles later; core[200] reads 0x00.
- LoadValid with LoadAddr=0x10, LoadData=0x5C while WriteMem=1 to 0x20 → LoadReady=0 that cycle; load completes the next cycle; both addresses read back correctly.
- READ_LATENCY=1, core[0x03]=0x11, same-cycle WriteMem 0x99 and ReadMem at 0x03 → DataOut=0x11 next cycle; repeat read → 0x99.
- DEPTH=200, AW=8: write 0xEE to address 0xF0 → dropped; read 0xF0 returns 0x00; core[0xC7] write/read works.
- DATA_MEM_WINDOW_EN, load-port write 0x42 to address 2 → WindowOut[2]=0x42 the cycle after transfer; without macro WindowOut stays 0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and default sizing for the parametrised data memory.
package data_mem_pkg;

  typedef enum logic {CLEAR, READY} state_e;

  localparam int DEF_W            = 8;
  localparam int DEF_AW           = 8;
  localparam int DEF_DEPTH        = 256;
  localparam int DEF_WIN          = 4;
  localparam int DEF_READ_LATENCY = 0;

endpackage

// File: rtl/data_mem_clear_seq.sv
// Post-reset clear sweep: zeroes one word per cycle, then raises ready.
module data_mem_clear_seq
  import data_mem_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready    = (state_q == READY);
  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/data_mem_ctl.sv
// Configurable data memory with CPU port, handshaked load port and clear sweep.
// Optional low-word mirror on WindowOut is enabled by defining DATA_MEM_WINDOW_EN.
module data_mem_ctl
  import data_mem_pkg::*;
#(
  parameter int W            = DEF_W,
  parameter int AW           = DEF_AW,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int WIN          = DEF_WIN
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [AW-1:0]  DataAddress,
  input  logic           ReadMem,
  input  logic           WriteMem,
  input  logic [W-1:0]   DataIn,
  output logic [W-1:0]   DataOut,
  output logic           Ready,
  input  logic           LoadValid,
  output logic           LoadReady,
  input  logic [AW-1:0]  LoadAddr,
  input  logic [W-1:0]   LoadData,
  output logic [WIN*W-1:0] WindowOut
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          cpu_in, load_in;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  core_q [DEPTH];

  data_mem_clear_seq #(.AW(AW), .DEPTH(DEPTH)) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .ready    (Ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  if (DEPTH >= (1 << AW)) begin : g_full_range
    assign cpu_in  = 1'b1;
    assign load_in = 1'b1;
  end else begin : g_part_range
    assign cpu_in  = (DataAddress < AW'(DEPTH));
    assign load_in = (LoadAddr < AW'(DEPTH));
  end

  assign LoadReady = Ready & ~WriteMem;

  // At most one writer per cycle: the sweep owns the array until Ready, then CPU beats load.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (!reset) begin
      if (clr_we) begin
        wr_en   = 1'b1;
        wr_addr = clr_addr;
      end else if (WriteMem) begin
        wr_en   = cpu_in;
        wr_addr = DataAddress;
        wr_data = DataIn;
      end else if (LoadValid && LoadReady) begin
        wr_en   = load_in;
        wr_addr = LoadAddr;
        wr_data = LoadData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) core_q[wr_addr[IW-1:0]] <= wr_data;
  end

  assign rd_data = cpu_in ? core_q[DataAddress[IW-1:0]] : '0;

  if (READ_LATENCY == 0) begin : g_comb_read
    logic unused_read_en;
    assign unused_read_en = ReadMem;
    assign DataOut        = rd_data;
  end else begin : g_reg_read
    logic [W-1:0] dout_q, dout_d;
    always_comb dout_d = ReadMem ? rd_data : dout_q;
    always_ff @(posedge clk) begin
      if (reset) dout_q <= '0;
      else       dout_q <= dout_d;
    end
    assign DataOut = dout_q;
  end

`ifdef DATA_MEM_WINDOW_EN
  logic [W-1:0] win_q [WIN];
  logic [W-1:0] win_d [WIN];

  always_comb begin
    win_d = win_q;
    for (int i = 0; i < WIN; i++) begin
      if (wr_en && (wr_addr == AW'(i))) win_d[i] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIN; i++) win_q[i] <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  always_comb begin
    WindowOut = '0;
    for (int i = 0; i < WIN; i++) WindowOut[i*W +: W] = win_q[i];
  end
`else
  assign WindowOut = '0;
`endif

endmodule

// File: tb/tb_data_mem_ctl.sv
// Self-checking bench: default instance (comb read, 256 words) and a
// registered-read 200-word instance share stimulus; a word-array model predicts both.
module tb_data_mem_ctl;

  localparam int W   = 8;
  localparam int AW  = 8;
  localparam int WIN = 4;
  localparam int D0  = 256;
  localparam int D1  = 200;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   DataAddress;
  logic            ReadMem, WriteMem;
  logic [W-1:0]    DataIn;
  logic            LoadValid;
  logic [AW-1:0]   LoadAddr;
  logic [W-1:0]    LoadData;

  logic [W-1:0]     dout0, dout1;
  logic             ready0, ready1, lrdy0, lrdy1;
  logic [WIN*W-1:0] win0, win1;

  always #5 clk = ~clk;

  data_mem_ctl u_dut0 (
    .clk(clk), .reset(reset), .DataAddress(DataAddress), .ReadMem(ReadMem),
    .WriteMem(WriteMem), .DataIn(DataIn), .DataOut(dout0), .Ready(ready0),
    .LoadValid(LoadValid), .LoadReady(lrdy0), .LoadAddr(LoadAddr),
    .LoadData(LoadData), .WindowOut(win0)
  );

  data_mem_ctl #(.READ_LATENCY(1), .DEPTH(D1)) u_dut1 (
    .clk(clk), .reset(reset), .DataAddress(DataAddress), .ReadMem(ReadMem),
    .WriteMem(WriteMem), .DataIn(DataIn), .DataOut(dout1), .Ready(ready1),
    .LoadValid(LoadValid), .LoadReady(lrdy1), .LoadAddr(LoadAddr),
    .LoadData(LoadData), .WindowOut(win1)
  );

  // Reference model: plain word arrays, a count of words cleared since reset,
  // and the last value latched by the registered-read instance.
  logic [W-1:0] mem0 [D0];
  logic [W-1:0] mem1 [D1];
  logic [W-1:0] wexp0 [WIN];
  logic [W-1:0] wexp1 [WIN];
  logic [W-1:0] exp_d1;
  int           n0, n1;
  bit           xfer;
  int           tests, fails;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] packWin(input logic [W-1:0] w [WIN]);
    logic [31:0] r;
    r = '0;
`ifdef DATA_MEM_WINDOW_EN
    for (int i = 0; i < WIN; i++) r[i*W +: W] = w[i];
`endif
    return r;
  endfunction

  task automatic modelEdge();
    xfer = 1'b0;
    if (reset) begin
      n0 = 0;
      n1 = 0;
      exp_d1 = '0;
      for (int i = 0; i < WIN; i++) begin
        wexp0[i] = '0;
        wexp1[i] = '0;
      end
    end else begin
      if (ReadMem) exp_d1 = (int'(DataAddress) < D1) ? mem1[DataAddress] : 8'h00;
      if (n0 < D0) begin
        mem0[n0] = '0;
        if (n0 < WIN) wexp0[n0] = '0;
        n0++;
      end else if (WriteMem) begin
        mem0[DataAddress] = DataIn;
        if (int'(DataAddress) < WIN) wexp0[DataAddress[1:0]] = DataIn;
      end else if (LoadValid) begin
        mem0[LoadAddr] = LoadData;
        if (int'(LoadAddr) < WIN) wexp0[LoadAddr[1:0]] = LoadData;
        xfer = 1'b1;
      end
      if (n1 < D1) begin
        mem1[n1] = '0;
        if (n1 < WIN) wexp1[n1] = '0;
        n1++;
      end else if (WriteMem) begin
        if (int'(DataAddress) < D1) mem1[DataAddress] = DataIn;
        if (int'(DataAddress) < WIN) wexp1[DataAddress[1:0]] = DataIn;
      end else if (LoadValid) begin
        if (int'(LoadAddr) < D1) mem1[LoadAddr] = LoadData;
        if (int'(LoadAddr) < WIN) wexp1[LoadAddr[1:0]] = LoadData;
      end
    end
  endtask

  task automatic checkComb();
    check("load_ready0", 32'(lrdy0), 32'((n0 == D0) && !WriteMem));
    check("load_ready1", 32'(lrdy1), 32'((n1 == D1) && !WriteMem));
    if (n0 == D0) check("comb_read0", 32'(dout0), 32'(mem0[DataAddress]));
  endtask

  task automatic checkOutput();
    check("ready0", 32'(ready0), 32'(n0 == D0));
    check("ready1", 32'(ready1), 32'(n1 == D1));
    check("load_ready0_post", 32'(lrdy0), 32'((n0 == D0) && !WriteMem));
    check("reg_read1", 32'(dout1), 32'(exp_d1));
    check("window0", 32'(win0), packWin(wexp0));
    check("window1", 32'(win1), packWin(wexp1));
  endtask

  task automatic applyStimulus(input bit r, input bit we, input bit re,
                               input logic [AW-1:0] a, input logic [W-1:0] d,
                               input bit lv, input logic [AW-1:0] la,
                               input logic [W-1:0] ld);
    reset = r; WriteMem = we; ReadMem = re; DataAddress = a; DataIn = d;
    LoadValid = lv; LoadAddr = la; LoadData = ld;
    #1;
    if (!r) checkComb();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
  endtask

  task automatic sweepLength(input string tag);
    int cnt;
    cnt = 0;
    while (!ready0 && cnt < 400) begin
      idle(1);
      cnt++;
    end
    check(tag, 32'(cnt), 32'(D0));
  endtask

  initial begin
    bit              pend;
    logic [AW-1:0]   pa;
    logic [W-1:0]    pd;
    tests = 0; fails = 0; n0 = 0; n1 = 0; exp_d1 = '0; pend = 0; pa = '0; pd = '0;
    for (int i = 0; i < D0; i++) mem0[i] = '0;
    for (int i = 0; i < D1; i++) mem1[i] = '0;
    for (int i = 0; i < WIN; i++) begin wexp0[i] = '0; wexp1[i] = '0; end

    // Reset for two cycles, then the full clear sweep
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    check("reset_ready", 32'(ready0), 32'd0);
    check("reset_dout1", 32'(dout1), 32'd0);
    sweepLength("sweep_len");
    idle(2);

    applyStimulus(0, 0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    applyStimulus(0, 0, 1, 8'h7F, 8'h00, 0, 8'h00, 8'h00);
    check("clr_rd_7f", 32'(dout1), 32'h00);
    applyStimulus(0, 0, 1, 8'hFF, 8'h00, 0, 8'h00, 8'h00);
    check("clr_rd_ff", 32'(dout1), 32'h00);

    // Reset in the middle of a sweep restarts it from word 0
    applyStimulus(0, 1, 0, 8'hC8, 8'hAA, 0, 8'h00, 8'h00);
    applyStimulus(0, 0, 1, 8'hC8, 8'h00, 0, 8'h00, 8'h00);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    idle(100);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    sweepLength("sweep_len_restart");
    applyStimulus(0, 0, 1, 8'hC8, 8'h00, 0, 8'h00, 8'h00);
    check("restart_rd_c8", 32'(dout0), 32'h00);

    // CPU write blocks the load port for one cycle
    applyStimulus(0, 1, 0, 8'h20, 8'h77, 1, 8'h10, 8'h5C);
    check("load_blocked", 32'(xfer), 32'd0);
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 1, 8'h10, 8'h5C);
    check("load_done", 32'(xfer), 32'd1);
    applyStimulus(0, 0, 1, 8'h10, 8'h00, 0, 8'h00, 8'h00);
    check("load_rd_10", 32'(dout1), 32'h5C);
    applyStimulus(0, 0, 1, 8'h20, 8'h00, 0, 8'h00, 8'h00);
    check("cpu_rd_20", 32'(dout1), 32'h77);

    // Registered read is read-first on a same-address write
    applyStimulus(0, 1, 0, 8'h03, 8'h11, 0, 8'h00, 8'h00);
    applyStimulus(0, 1, 1, 8'h03, 8'h99, 0, 8'h00, 8'h00);
    check("read_first_old", 32'(dout1), 32'h11);
    applyStimulus(0, 0, 1, 8'h03, 8'h00, 0, 8'h00, 8'h00);
    check("read_first_new", 32'(dout1), 32'h99);

    // Out-of-range write on the 200-word instance is dropped
    applyStimulus(0, 1, 0, 8'hF0, 8'hEE, 0, 8'h00, 8'h00);
    applyStimulus(0, 0, 1, 8'hF0, 8'h00, 0, 8'h00, 8'h00);
    check("oor_rd_f0", 32'(dout1), 32'h00);
    check("inrange_rd_f0", 32'(dout0), 32'hEE);
    applyStimulus(0, 1, 0, 8'hC7, 8'h3C, 0, 8'h00, 8'h00);
    applyStimulus(0, 0, 1, 8'hC7, 8'h00, 0, 8'h00, 8'h00);
    check("edge_rd_c7", 32'(dout1), 32'h3C);

    // Load into a mirrored word
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 1, 8'h02, 8'h42);
`ifdef DATA_MEM_WINDOW_EN
    check("window_word2", 32'(win0[23:16]), 32'h42);
`else
    check("window_off", 32'(win0), 32'h0);
`endif

    // Randomised traffic with a held-until-accepted load request
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] a;
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1;
        pa = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
        pd = 8'($urandom);
      end
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      applyStimulus(0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                    a, 8'($urandom), pend, pa, pd);
      if (xfer) pend = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
